// File: rtl/alsaqr_pad_ctrl_pkg.sv
// rtl/alsaqr_pad_ctrl_pkg.sv - register offsets, pad configuration type and reset value
package alsaqr_pad_ctrl_pkg;

    // Byte offsets of the register map.
    localparam logic [7:0] ADDR_DIR     = 8'h00;
    localparam logic [7:0] ADDR_OUT     = 8'h04;
    localparam logic [7:0] ADDR_IN      = 8'h08;
    localparam logic [7:0] ADDR_IRQ_EN  = 8'h0C;
    localparam logic [7:0] ADDR_IRQ_STS = 8'h10;
    localparam logic [7:0] ADDR_PADCFG0 = 8'h20;

    // Word indices; the two low address bits never take part in decoding.
    localparam logic [5:0] WORD_DIR     = ADDR_DIR[7:2];
    localparam logic [5:0] WORD_OUT     = ADDR_OUT[7:2];
    localparam logic [5:0] WORD_IN      = ADDR_IN[7:2];
    localparam logic [5:0] WORD_IRQ_EN  = ADDR_IRQ_EN[7:2];
    localparam logic [5:0] WORD_IRQ_STS = ADDR_IRQ_STS[7:2];
    localparam logic [5:0] WORD_PADCFG0 = ADDR_PADCFG0[7:2];

    // Per-pad electrical configuration, laid out as the PADCFG register bits [4:0].
    typedef struct packed {
        logic       smt;
        logic       slw;
        logic       puen;
        logic [1:0] drv;
    } pad_cfg_t;

    // Pull disabled (puen is active-low), weakest drive, fast slew, no Schmitt.
    localparam pad_cfg_t PAD_CFG_RST = '{smt: 1'b0, slw: 1'b0, puen: 1'b1, drv: 2'b00};

    // Word index of PADCFG[idx].
    function automatic logic [5:0] padcfg_word(input int idx);
        return WORD_PADCFG0 + 6'(idx);
    endfunction

endpackage

// File: rtl/alsaqr_pad_in_filt.sv
// rtl/alsaqr_pad_in_filt.sv - one-pad input synchronizer with optional glitch filter (ALSAQR_PAD_GLITCH_FILTER_EN)
module alsaqr_pad_in_filt #(
    parameter int FILT_CYC = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic pad_i,
    output logic val_o
);

    // Out-of-range filter length leaves this named marker in the elaborated hierarchy.
    if ((FILT_CYC < 2) || (FILT_CYC > 255)) begin : g_filt_cyc_illegal
    end

    logic [1:0] sync_q;

    // Two-flop synchronizer for the asynchronous pad input.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], pad_i};
        end
    end

`ifdef ALSAQR_PAD_GLITCH_FILTER_EN
    localparam logic [7:0] FILT_LAST = 8'(FILT_CYC - 1);

    logic [7:0] cnt_q;
    logic       val_q;

    // Accept a new level only after it has differed from the output for FILT_CYC straight cycles.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= 8'd0;
            val_q <= 1'b0;
        end else if (sync_q[1] == val_q) begin
            cnt_q <= 8'd0;
        end else if (cnt_q == FILT_LAST) begin
            cnt_q <= 8'd0;
            val_q <= sync_q[1];
        end else begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    assign val_o = val_q;
`else
    assign val_o = sync_q[1];
`endif

endmodule

// File: rtl/alsaqr_pad_ctrl.sv
// rtl/alsaqr_pad_ctrl.sv - pad controller top: registers, pad outputs, input edge interrupts (ALSAQR_PAD_GLITCH_FILTER_EN)
import alsaqr_pad_ctrl_pkg::*;

module alsaqr_pad_ctrl #(
    parameter int NPADS    = 8,
    parameter int FILT_CYC = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               reg_req_i,
    output logic               reg_gnt_o,
    input  logic               reg_we_i,
    input  logic [7:0]         reg_addr_i,
    input  logic [31:0]        reg_wdata_i,
    output logic               reg_rvalid_o,
    output logic [31:0]        reg_rdata_o,
    output logic [NPADS-1:0]   pad_oen_o,
    output logic [NPADS-1:0]   pad_i_o,
    input  logic [NPADS-1:0]   pad_o_i,
    output logic [2*NPADS-1:0] pad_drv_o,
    output logic [NPADS-1:0]   pad_puen_o,
    output logic [NPADS-1:0]   pad_slw_o,
    output logic [NPADS-1:0]   pad_smt_o,
    output logic               irq_o
);

    // Out-of-range pad count leaves this named marker in the elaborated hierarchy.
    if ((NPADS < 1) || (NPADS > 32)) begin : g_npads_illegal
    end

    logic [NPADS-1:0] dir_q;
    logic [NPADS-1:0] out_q;
    logic [NPADS-1:0] irq_en_q;
    logic [NPADS-1:0] irq_sts_q;
    logic [NPADS-1:0] in_val;
    logic [NPADS-1:0] in_prev_q;
    pad_cfg_t         cfg_q [NPADS];

    // Edges are ignored until the synchronizer has delivered a real post-reset sample.
    logic [2:0]       arm_q;

    logic             rvalid_q;
    logic [31:0]      rdata_q;

    logic [5:0]       word;
    logic             wr;
    logic [NPADS-1:0] cfg_sel;
    logic [31:0]      rd_word;
    logic [NPADS-1:0] sts_set;
    logic [NPADS-1:0] sts_clr;

    assign word      = reg_addr_i[7:2];
    assign wr        = reg_req_i & reg_we_i;
    assign reg_gnt_o = reg_req_i;

    for (genvar i = 0; i < NPADS; i++) begin : g_pad_in
        alsaqr_pad_in_filt #(
            .FILT_CYC (FILT_CYC)
        ) u_filt (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .pad_i  (pad_o_i[i]),
            .val_o  (in_val[i])
        );
    end

    // PADCFG decode; indices at or beyond NPADS select nothing.
    always_comb begin
        cfg_sel = '0;
        for (int i = 0; i < NPADS; i++) begin
            cfg_sel[i] = (word == padcfg_word(i));
        end
    end

    // Read mux; unmapped words read as zero.
    always_comb begin
        rd_word = '0;
        case (word)
            WORD_DIR:     rd_word = 32'(dir_q);
            WORD_OUT:     rd_word = 32'(out_q);
            WORD_IN:      rd_word = 32'(in_val);
            WORD_IRQ_EN:  rd_word = 32'(irq_en_q);
            WORD_IRQ_STS: rd_word = 32'(irq_sts_q);
            default:      rd_word = '0;
        endcase
        for (int i = 0; i < NPADS; i++) begin
            if (cfg_sel[i]) begin
                rd_word = 32'(cfg_q[i]);
            end
        end
    end

    // Rising-edge sets and W1C clears of the status register; a set in the same cycle wins.
    always_comb begin
        sts_set = (in_val & ~in_prev_q) & irq_en_q & {NPADS{arm_q[2]}};
        sts_clr = (wr && (word == WORD_IRQ_STS)) ? reg_wdata_i[NPADS-1:0] : '0;
    end

    // Register file, edge history and one-cycle read response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dir_q     <= '0;
            out_q     <= '0;
            irq_en_q  <= '0;
            irq_sts_q <= '0;
            in_prev_q <= '0;
            arm_q     <= 3'b000;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            for (int i = 0; i < NPADS; i++) begin
                cfg_q[i] <= PAD_CFG_RST;
            end
        end else begin
            if (wr && (word == WORD_DIR))    dir_q    <= reg_wdata_i[NPADS-1:0];
            if (wr && (word == WORD_OUT))    out_q    <= reg_wdata_i[NPADS-1:0];
            if (wr && (word == WORD_IRQ_EN)) irq_en_q <= reg_wdata_i[NPADS-1:0];
            for (int i = 0; i < NPADS; i++) begin
                if (wr && cfg_sel[i]) begin
                    cfg_q[i] <= pad_cfg_t'(reg_wdata_i[4:0]);
                end
            end
            irq_sts_q <= (irq_sts_q & ~sts_clr) | sts_set;
            in_prev_q <= in_val;
            arm_q     <= {arm_q[1:0], 1'b1};
            rvalid_q  <= reg_req_i;
            rdata_q   <= (reg_req_i && !reg_we_i) ? rd_word : '0;
        end
    end

    // Pad-facing outputs come straight from the register flops.
    always_comb begin
        pad_oen_o  = ~dir_q;
        pad_i_o    = out_q;
        pad_drv_o  = '0;
        pad_puen_o = '0;
        pad_slw_o  = '0;
        pad_smt_o  = '0;
        for (int i = 0; i < NPADS; i++) begin
            pad_drv_o[2*i +: 2] = cfg_q[i].drv;
            pad_puen_o[i]       = cfg_q[i].puen;
            pad_slw_o[i]        = cfg_q[i].slw;
            pad_smt_o[i]        = cfg_q[i].smt;
        end
    end

    assign reg_rvalid_o = rvalid_q;
    assign reg_rdata_o  = rdata_q;
    assign irq_o        = |(irq_sts_q & irq_en_q);

endmodule

// File: tb/tb_alsaqr_pad_ctrl.sv
// tb/tb_alsaqr_pad_ctrl.sv - scoreboard bench for alsaqr_pad_ctrl (ALSAQR_PAD_GLITCH_FILTER_EN aware)
module tb_alsaqr_pad_ctrl;

    localparam int NPADS    = 8;
    localparam int FILT_CYC = 4;
`ifdef ALSAQR_PAD_GLITCH_FILTER_EN
    localparam int IRQ_LAT = 3 + FILT_CYC;
`else
    localparam int IRQ_LAT = 3;
`endif

    logic               clk;
    logic               rst_n;
    logic               req;
    logic               gnt;
    logic               we;
    logic [7:0]         addr;
    logic [31:0]        wdata;
    logic               rvalid;
    logic [31:0]        rdata;
    logic [NPADS-1:0]   oen;
    logic [NPADS-1:0]   pout;
    logic [NPADS-1:0]   pin;
    logic [2*NPADS-1:0] drv;
    logic [NPADS-1:0]   puen;
    logic [NPADS-1:0]   slw;
    logic [NPADS-1:0]   smt;
    logic               irq;

    alsaqr_pad_ctrl #(
        .NPADS    (NPADS),
        .FILT_CYC (FILT_CYC)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .reg_req_i    (req),
        .reg_gnt_o    (gnt),
        .reg_we_i     (we),
        .reg_addr_i   (addr),
        .reg_wdata_i  (wdata),
        .reg_rvalid_o (rvalid),
        .reg_rdata_o  (rdata),
        .pad_oen_o    (oen),
        .pad_i_o      (pout),
        .pad_o_i      (pin),
        .pad_drv_o    (drv),
        .pad_puen_o   (puen),
        .pad_slw_o    (slw),
        .pad_smt_o    (smt),
        .irq_o        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int          due;
        string       name;
    } exp_t;

    exp_t sbq[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // Issue one granted access; the response it must produce goes on the scoreboard.
    task automatic acc(input string name, input logic w, input logic [7:0] a,
                       input logic [31:0] d, input logic [31:0] exp);
        exp_t e;
        @(negedge clk);
        req   = 1'b1;
        we    = w;
        addr  = a;
        wdata = d;
        e.data = w ? 32'h0 : exp;
        e.due  = cyc + 1;
        e.name = name;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        req = 1'b0;
        we  = 1'b0;
    endtask

    // Response monitor: every rvalid must match the oldest outstanding access, on time.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (rvalid) begin
                if (sbq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_rvalid actual=1 expected=0 rdata=0x%08h", rdata);
                end else begin
                    e = sbq.pop_front();
                    chk(e.name, rdata, e.data);
                    chk({e.name, "_lat"}, cyc, e.due);
                end
            end else if (sbq.size() > 0 && cyc > sbq[0].due) begin
                e = sbq.pop_front();
                checks++;
                failures++;
                $display("FAIL %s_missing_rvalid actual=0 expected=1", e.name);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        req   = 1'b0;
        we    = 1'b0;
        addr  = 8'h00;
        wdata = 32'h0;
        pin   = '0;
        repeat (3) @(negedge clk);

        chk("rst_oen",    oen,    32'hFF);
        chk("rst_pad_i",  pout,   32'h00);
        chk("rst_puen",   puen,   32'hFF);
        chk("rst_drv",    drv,    32'h0);
        chk("rst_slw",    slw,    32'h0);
        chk("rst_smt",    smt,    32'h0);
        chk("rst_irq",    irq,    32'h0);
        chk("rst_rvalid", rvalid, 32'h0);
        chk("rst_rdata",  rdata,  32'h0);
        req = 1'b1;
        #1 chk("gnt_req1", gnt, 32'h1);
        req = 1'b0;
        #1 chk("gnt_req0", gnt, 32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        acc("rd_padcfg0_rst", 1'b0, 8'h20, 32'h0, 32'h04);
        acc("rd_dir_rst",     1'b0, 8'h00, 32'h0, 32'h00);

        acc("wr_dir", 1'b1, 8'h00, 32'h1, 32'h0);
        acc("wr_out", 1'b1, 8'h04, 32'h1, 32'h0);
        @(negedge clk);
        chk("oen_after_dir",  oen,  32'hFE);
        chk("pad_i_after_out", pout, 32'h01);

        acc("wr_dir_all",  1'b1, 8'h00, 32'hFFFF_FFFF, 32'h0);
        acc("rd_dir_mask", 1'b0, 8'h03, 32'h0, 32'hFF);
        acc("wr_dir_back", 1'b1, 8'h00, 32'h1, 32'h0);

        acc("wr_cfg3", 1'b1, 8'h2C, 32'h1B, 32'h0);
        @(negedge clk);
        chk("cfg3_drv",  drv[7:6], 32'h3);
        chk("cfg3_slw",  slw[3],   32'h1);
        chk("cfg3_smt",  smt[3],   32'h1);
        chk("cfg3_puen", puen,     32'hF7);
        acc("rd_cfg3",   1'b0, 8'h2C, 32'h0, 32'h1B);
        acc("wr_cfg5",   1'b1, 8'h34, 32'hFFFF_FFFF, 32'h0);
        acc("rd_cfg5",   1'b0, 8'h34, 32'h0, 32'h1F);

        acc("wr_oor",      1'b1, 8'h40, 32'hFF, 32'h0);
        acc("rd_oor",      1'b0, 8'h40, 32'h0, 32'h0);
        acc("wr_unmapped", 1'b1, 8'h14, 32'hFF, 32'h0);
        acc("rd_unmapped", 1'b0, 8'h14, 32'h0, 32'h0);
        acc("wr_in_ro",    1'b1, 8'h08, 32'hFF, 32'h0);
        acc("rd_in_zero",  1'b0, 8'h08, 32'h0, 32'h0);

        acc("wr_irq_en", 1'b1, 8'h0C, 32'h04, 32'h0);
        @(negedge clk);
        pin[2] = 1'b1;
        repeat (IRQ_LAT - 1) @(posedge clk);
        @(negedge clk);
        chk("irq_before_edge", irq, 32'h0);
        @(posedge clk);
        @(negedge clk);
        chk("irq_after_edge", irq, 32'h1);
        acc("rd_sts_set", 1'b0, 8'h10, 32'h0, 32'h04);
        acc("rd_in_set",  1'b0, 8'h08, 32'h0, 32'h04);
        acc("w1c_sts",    1'b1, 8'h10, 32'h04, 32'h0);
        @(negedge clk);
        chk("irq_after_w1c", irq, 32'h0);
        acc("rd_sts_clr", 1'b0, 8'h10, 32'h0, 32'h00);

`ifdef ALSAQR_PAD_GLITCH_FILTER_EN
        acc("wr_irq_en_b1", 1'b1, 8'h0C, 32'h06, 32'h0);
        @(negedge clk);
        pin[1] = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        pin[1] = 1'b0;
        repeat (12) @(posedge clk);
        acc("rd_in_glitch",  1'b0, 8'h08, 32'h0, 32'h04);
        acc("rd_sts_glitch", 1'b0, 8'h10, 32'h0, 32'h00);
        chk("irq_glitch", irq, 32'h0);
        @(negedge clk);
        pin[1] = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        pin[1] = 1'b0;
        repeat (12) @(posedge clk);
        acc("rd_sts_pulse5", 1'b0, 8'h10, 32'h0, 32'h02);
        chk("irq_pulse5", irq, 32'h1);
        acc("w1c_b1", 1'b1, 8'h10, 32'h02, 32'h0);
        acc("rd_in_after5", 1'b0, 8'h08, 32'h0, 32'h04);
`endif

        @(negedge clk);
        pin[2] = 1'b0;
        repeat (IRQ_LAT + 2) @(posedge clk);
        acc("rd_sts_fall", 1'b0, 8'h10, 32'h0, 32'h00);
        @(negedge clk);
        pin[2] = 1'b1;
        repeat (IRQ_LAT - 1) @(posedge clk);
        acc("w1c_race", 1'b1, 8'h10, 32'h04, 32'h0);
        @(negedge clk);
        chk("irq_race", irq, 32'h1);
        acc("rd_sts_race", 1'b0, 8'h10, 32'h0, 32'h04);

        @(negedge clk);
        req  = 1'b1;
        we   = 1'b0;
        addr = 8'h08;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        req   = 1'b0;
        @(negedge clk);
        chk("midrst_rvalid", rvalid, 32'h0);
        chk("midrst_rdata",  rdata,  32'h0);
        chk("midrst_oen",    oen,    32'hFF);
        chk("midrst_pad_i",  pout,   32'h00);
        chk("midrst_puen",   puen,   32'hFF);
        chk("midrst_drv",    drv,    32'h0);
        chk("midrst_slw",    slw,    32'h0);
        chk("midrst_smt",    smt,    32'h0);
        chk("midrst_irq",    irq,    32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        acc("rd_dir_postrst", 1'b0, 8'h00, 32'h0, 32'h00);
        acc("rd_sts_postrst", 1'b0, 8'h10, 32'h0, 32'h00);

        repeat (3) @(negedge clk);
        chk("sb_drained", sbq.size(), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alsaqr_pad_ctrl.md
ALSAQR_PAD_CTRL -- requirements
Module: alsaqr_pad_ctrl

Interface
REQ-001 Parameter NPADS, default 8, number of pads driven; legal range 1..32.
REQ-002 Parameter FILT_CYC, default 4, input glitch-filter stable count; legal range 2..255.
REQ-003 Port clk_i  input  1  single clock; all state on its rising edge.
REQ-004 Port rst_ni  input  1  reset; asynchronous, active-low.
REQ-005 Port reg_req_i  input  1  register access request.
REQ-006 Port reg_gnt_o  output  1  request accepted.
REQ-007 Port reg_we_i  input  1  1=write, 0=read.
REQ-008 Port reg_addr_i  input  8  byte address; bits [1:0] ignored.
REQ-009 Port reg_wdata_i  input  32  write data.
REQ-010 Port reg_rvalid_o  output  1  response valid.
REQ-011 Port reg_rdata_o  output  32  read data.
REQ-012 Port pad_oen_o  output  NPADS  per-pad output enable, active-low.
REQ-013 Port pad_i_o  output  NPADS  per-pad output value.
REQ-014 Port pad_o_i  input  NPADS  per-pad received value, asynchronous to clk_i.
REQ-015 Port pad_drv_o  output  NPADS x 2  per-pad drive strength.
REQ-016 Port pad_puen_o, pad_slw_o, pad_smt_o  output  NPADS each  pull enable (active-low), slew, Schmitt.
REQ-017 Port irq_o  output  1  level interrupt.

Function
REQ-018 Register map: 0x00 DIR (1=output), 0x04 OUT, 0x08 IN (RO), 0x0C IRQ_EN, 0x10 IRQ_STS (W1C), 0x20+4*i PADCFG[i] with [1:0] DRV, [2] PUEN, [3] SLW, [4] SMT.
REQ-019 reg_gnt_o SHALL equal reg_req_i combinationally; no back-pressure.
REQ-020 reg_rvalid_o SHALL assert exactly one cycle after every granted access, read or write; reg_rdata_o valid in that cycle, 0 for writes.
REQ-021 Writes SHALL take effect on the grant edge; outputs update the following cycle.
REQ-022 Unmapped or out-of-range (pad index >= NPADS) addresses: writes ignored, reads return 0, rvalid still issued.
REQ-023 Bits at or above NPADS in DIR/OUT/IN/IRQ_EN/IRQ_STS SHALL read 0 and ignore writes.
REQ-024 pad_oen_o[i] = ~DIR[i]; pad_i_o[i] = OUT[i]; cfg outputs driven straight from PADCFG flops.
REQ-025 pad_o_i SHALL pass a two-flop synchronizer; IN reflects the (filtered) synchronized value.
REQ-026 Rising edge of IN[i] with IRQ_EN[i]=1 SHALL set IRQ_STS[i] the cycle after IN changes.
REQ-027 Same-cycle set and W1C clear of one IRQ_STS bit: set wins.
REQ-028 irq_o = |(IRQ_STS & IRQ_EN), registered-free OR of flops.
REQ-029 Reads of IN SHALL return the value present at the grant edge.

Reset
REQ-030 On rst_ni low: DIR=0, OUT=0, IRQ_EN=0, IRQ_STS=0, PADCFG[i]=0x04 (DRV=0, PUEN=1 i.e. pull off, SLW=0, SMT=0).
REQ-031 Reset outputs: pad_oen_o all 1, pad_i_o 0, reg_gnt_o follows req, reg_rvalid_o 0, reg_rdata_o 0, irq_o 0.
REQ-032 Synchronizer and filter flops reset to 0; edge detector SHALL NOT fire on the first post-reset sample.
REQ-033 Reset asserted mid-access SHALL drop the pending rvalid.

Configuration
REQ-034 Macro ALSAQR_PAD_GLITCH_FILTER_EN defined: per-pad counter; IN[i] updates only after the synchronized value differs from IN[i] for FILT_CYC consecutive cycles; counter restarts on any reversion.
REQ-035 Macro undefined: IN = synchronized value directly; no counters instantiated; FILT_CYC unused.

Structure
REQ-036 Package alsaqr_pad_ctrl_pkg SHALL hold register offsets, pad_cfg_t packed struct (drv, puen, slw, smt) and its reset value.
REQ-037 One sub-module alsaqr_pad_in_filt (synchronizer + optional filter, one pad) instantiated NPADS times.

Verification
REQ-038 Write DIR=0x01, OUT=0x01 -> pad_oen_o[0]=0, pad_i_o[0]=1 next cycle; rvalid one cycle after each grant.
REQ-039 Write PADCFG[3]=0x1B -> pad_drv_o[3]=2'b11, pad_slw_o[3]=1, pad_smt_o[3]=1, pad_puen_o[3]=0; read back 0x1B.
REQ-040 IRQ_EN=0x04, pad_o_i[2] 0->1 -> IRQ_STS=0x04 and irq_o=1 after sync (+FILT_CYC with macro); W1C 0x04 -> irq_o=0.
REQ-041 Macro on, FILT_CYC=4: 3-cycle pulse on pad_o_i[1] -> IN unchanged, no IRQ; 5-cycle pulse -> IN[1] toggles.
REQ-042 Edge arrives same cycle as W1C of that bit -> IRQ_STS bit remains 1.
REQ-043 Read 0x40 with NPADS=8, and rst_ni pulsed mid-read -> rdata 0 / rvalid suppressed; all outputs at REQ-030/031 values.
